// File: rtl/iob_dma_sched_pkg.sv
// Shared definitions for the iob_dma descriptor sequencer: DMA CSR map,
// FSM state encodings and the packed descriptor width helper.
package iob_dma_sched_pkg;

  // CSR word addresses of the iob_dma register bank
  localparam int unsigned BASE_ADDR     = 0;
  localparam int unsigned TRANSFER_SIZE = 1;
  localparam int unsigned DIRECTION     = 2;
  localparam int unsigned INTERFACE_NUM = 3;
  localparam int unsigned READY_W       = 4;
  localparam int unsigned READY_R       = 5;

  localparam logic [3:0] ST_IDLE      = 4'd0;
  localparam logic [3:0] ST_LOAD      = 4'd1;
  localparam logic [3:0] ST_WR_IF     = 4'd2;
  localparam logic [3:0] ST_WR_DIR    = 4'd3;
  localparam logic [3:0] ST_WR_A      = 4'd4;
  localparam logic [3:0] ST_WR_B      = 4'd5;
  localparam logic [3:0] ST_SETTLE    = 4'd6;
  localparam logic [3:0] ST_POLL_REQ  = 4'd7;
  localparam logic [3:0] ST_POLL_WAIT = 4'd8;
  localparam logic [3:0] ST_RETIRE    = 4'd9;

  function automatic int desc_width(input int addr_w, input int size_w, input int if_w);
    return addr_w + size_w + 1 + if_w;
  endfunction

endpackage

// File: rtl/iob_dma_sched_fifo.sv
// Register FIFO holding packed descriptors; registered occupancy and a
// single-cycle flush that drops any same-cycle push.
module iob_dma_sched_fifo #(
  parameter int W          = 69,
  parameter int DEPTH_LOG2 = 3
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  cke,
  input  logic                  push,
  input  logic                  pop,
  input  logic                  flush,
  input  logic [W-1:0]          wdata,
  output logic [W-1:0]          rdata,
  output logic [DEPTH_LOG2:0]   level,
  output logic                  full,
  output logic                  empty
);

  localparam int DEPTH   = 2 ** DEPTH_LOG2;
  localparam int LEVEL_W = DEPTH_LOG2 + 1;

  logic [W-1:0]            mem [DEPTH];
  logic [DEPTH_LOG2-1:0]   wr_ptr;
  logic [DEPTH_LOG2-1:0]   rd_ptr;
  logic                    do_push;
  logic                    do_pop;

  assign full    = (level == LEVEL_W'(DEPTH));
  assign empty   = (level == '0);
  assign do_push = cke & push & ~full & ~flush;
  assign do_pop  = cke & pop & ~empty;
  assign rdata   = mem[rd_ptr];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      level  <= '0;
    end else if (cke & flush) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      level  <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + DEPTH_LOG2'(1);
      if (do_pop)  rd_ptr <= rd_ptr + DEPTH_LOG2'(1);
      if (do_push & ~do_pop)
        level <= level + LEVEL_W'(1);
      else if (do_pop & ~do_push)
        level <= level - LEVEL_W'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr] <= wdata;
  end

endmodule

// File: rtl/iob_dma_sched.sv
// Descriptor-driven sequencer for the iob_dma CSR port: programs each queued
// transfer, waits for the start pulse to settle, then polls until done.
module iob_dma_sched
  import iob_dma_sched_pkg::*;
#(
  parameter int ADDR_W     = 32,
  parameter int SIZE_W     = 32,
  parameter int IF_W       = 4,
  parameter int CSR_ADDR_W = 4,
  parameter int DEPTH_LOG2 = 3,
  parameter int SETTLE_CYC = 4
) (
  input  logic                  clk_i,
  input  logic                  arst_n_i,
  input  logic                  cke_i,
  input  logic                  desc_valid_i,
  output logic                  desc_ready_o,
  input  logic [ADDR_W-1:0]     desc_addr_i,
  input  logic [SIZE_W-1:0]     desc_size_i,
  input  logic                  desc_dir_i,
  input  logic [IF_W-1:0]       desc_if_i,
  input  logic                  flush_i,
  output logic                  busy_o,
  output logic                  done_o,
  output logic [15:0]           done_cnt_o,
  output logic [DEPTH_LOG2:0]   level_o,
  output logic                  iob_valid_o,
  output logic [CSR_ADDR_W-1:0] iob_addr_o,
  output logic [31:0]           iob_wdata_o,
  output logic [3:0]            iob_wstrb_o,
  input  logic                  iob_ready_i,
  input  logic                  iob_rvalid_i,
  input  logic [31:0]           iob_rdata_i
);

  localparam int DESC_W = desc_width(ADDR_W, SIZE_W, IF_W);
  localparam int SC_W   = $clog2(SETTLE_CYC + 1);

  logic [3:0]          state;
  logic [ADDR_W-1:0]   cur_addr;
  logic [SIZE_W-1:0]   cur_size;
  logic                cur_dir;
  logic [IF_W-1:0]     cur_if;
  logic [SC_W-1:0]     settle_cnt;
  logic [15:0]         done_cnt;
  logic [DESC_W-1:0]   push_desc;
  logic [DESC_W-1:0]   head_desc;
  logic                fifo_full;
  logic                fifo_empty;
  logic                pop;
  logic                poll_done;
  logic                unused_rdata;

  assign push_desc    = {desc_addr_i, desc_size_i, desc_dir_i, desc_if_i};
  assign pop          = (state == ST_IDLE) & ~fifo_empty;
  assign desc_ready_o = ~fifo_full;
  assign poll_done    = iob_rdata_i[0];
  assign unused_rdata = ^iob_rdata_i[31:1];

  iob_dma_sched_fifo #(
    .W          (DESC_W),
    .DEPTH_LOG2 (DEPTH_LOG2)
  ) fifo (
    .clk   (clk_i),
    .rst_n (arst_n_i),
    .cke   (cke_i),
    .push  (desc_valid_i),
    .pop   (pop),
    .flush (flush_i),
    .wdata (push_desc),
    .rdata (head_desc),
    .level (level_o),
    .full  (fifo_full),
    .empty (fifo_empty)
  );

  // The head is captured on the pop edge so LOAD already holds the descriptor
  always_ff @(posedge clk_i or negedge arst_n_i) begin
    if (!arst_n_i) begin
      state      <= ST_IDLE;
      cur_addr   <= '0;
      cur_size   <= '0;
      cur_dir    <= 1'b0;
      cur_if     <= '0;
      settle_cnt <= '0;
      done_cnt   <= '0;
    end else if (cke_i) begin
      case (state)
        ST_IDLE: begin
          if (pop) begin
            {cur_addr, cur_size, cur_dir, cur_if} <= head_desc;
            state <= ST_LOAD;
          end
        end
        ST_LOAD:   state <= (cur_size == '0) ? ST_RETIRE : ST_WR_IF;
        ST_WR_IF:  if (iob_ready_i) state <= ST_WR_DIR;
        ST_WR_DIR: if (iob_ready_i) state <= ST_WR_A;
        ST_WR_A:   if (iob_ready_i) state <= ST_WR_B;
        ST_WR_B: begin
          if (iob_ready_i) begin
            settle_cnt <= '0;
            state      <= ST_SETTLE;
          end
        end
        ST_SETTLE: begin
          if (settle_cnt == SC_W'(SETTLE_CYC - 1))
            state <= ST_POLL_REQ;
          else
            settle_cnt <= settle_cnt + SC_W'(1);
        end
        ST_POLL_REQ: begin
          if (iob_ready_i) begin
            if (iob_rvalid_i)
              state <= poll_done ? ST_RETIRE : ST_POLL_REQ;
            else
              state <= ST_POLL_WAIT;
          end
        end
        ST_POLL_WAIT: begin
          if (iob_rvalid_i) state <= poll_done ? ST_RETIRE : ST_POLL_REQ;
        end
        ST_RETIRE: begin
          done_cnt <= done_cnt + 16'd1;
          state    <= ST_IDLE;
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

  // Size-first order for writes to memory clears the stream counter before start
  always_comb begin
    iob_valid_o = 1'b0;
    iob_addr_o  = '0;
    iob_wdata_o = '0;
    iob_wstrb_o = 4'h0;
    case (state)
      ST_WR_IF: begin
        iob_valid_o = 1'b1;
        iob_addr_o  = CSR_ADDR_W'(INTERFACE_NUM);
        iob_wdata_o = 32'(cur_if);
        iob_wstrb_o = 4'hF;
      end
      ST_WR_DIR: begin
        iob_valid_o = 1'b1;
        iob_addr_o  = CSR_ADDR_W'(DIRECTION);
        iob_wdata_o = 32'(cur_dir);
        iob_wstrb_o = 4'hF;
      end
      ST_WR_A: begin
        iob_valid_o = 1'b1;
        iob_addr_o  = cur_dir ? CSR_ADDR_W'(TRANSFER_SIZE) : CSR_ADDR_W'(BASE_ADDR);
        iob_wdata_o = cur_dir ? 32'(cur_size) : 32'(cur_addr);
        iob_wstrb_o = 4'hF;
      end
      ST_WR_B: begin
        iob_valid_o = 1'b1;
        iob_addr_o  = cur_dir ? CSR_ADDR_W'(BASE_ADDR) : CSR_ADDR_W'(TRANSFER_SIZE);
        iob_wdata_o = cur_dir ? 32'(cur_addr) : 32'(cur_size);
        iob_wstrb_o = 4'hF;
      end
      ST_POLL_REQ: begin
        iob_valid_o = 1'b1;
        iob_addr_o  = cur_dir ? CSR_ADDR_W'(READY_W) : CSR_ADDR_W'(READY_R);
      end
      default: ;
    endcase
  end

  assign done_o     = (state == ST_RETIRE);
  assign done_cnt_o = done_cnt;
  assign busy_o     = (state != ST_IDLE) | (level_o != '0);

endmodule

// File: tb/tb_iob_dma_sched.sv
// Randomized bench for iob_dma_sched: a CSR slave with random stalls and poll
// answers, checked against a descriptor-queue model of the expected traffic.
module tb_iob_dma_sched;
  import iob_dma_sched_pkg::*;

  localparam int SETTLE = 4;

  typedef struct packed {
    logic [31:0] addr;
    logic [31:0] size;
    logic        dir;
    logic [3:0]  ifn;
  } desc_t;

  logic        clk;
  logic        arst_n;
  logic        cke;
  logic        desc_valid;
  logic        desc_ready;
  logic [31:0] desc_addr;
  logic [31:0] desc_size;
  logic        desc_dir;
  logic [3:0]  desc_if;
  logic        flush;
  logic        busy;
  logic        done;
  logic [15:0] done_cnt;
  logic [3:0]  level;
  logic        iob_valid;
  logic [3:0]  iob_addr;
  logic [31:0] iob_wdata;
  logic [3:0]  iob_wstrb;
  logic        iob_ready;
  logic        iob_rvalid;
  logic [31:0] iob_rdata;

  iob_dma_sched #(
    .ADDR_W(32), .SIZE_W(32), .IF_W(4), .CSR_ADDR_W(4), .DEPTH_LOG2(3), .SETTLE_CYC(SETTLE)
  ) dut (
    .clk_i(clk), .arst_n_i(arst_n), .cke_i(cke),
    .desc_valid_i(desc_valid), .desc_ready_o(desc_ready),
    .desc_addr_i(desc_addr), .desc_size_i(desc_size), .desc_dir_i(desc_dir), .desc_if_i(desc_if),
    .flush_i(flush), .busy_o(busy), .done_o(done), .done_cnt_o(done_cnt), .level_o(level),
    .iob_valid_o(iob_valid), .iob_addr_o(iob_addr), .iob_wdata_o(iob_wdata), .iob_wstrb_o(iob_wstrb),
    .iob_ready_i(iob_ready), .iob_rvalid_i(iob_rvalid), .iob_rdata_i(iob_rdata)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  int checks = 0;
  int errors = 0;

  desc_t model_q[$];
  int    done_model = 0;
  int    wait_fixed = -1;
  int    rv_fixed   = -1;
  int    zero_fixed = -1;
  bit    rv_hold    = 0;

  bit          active = 0;
  desc_t       cur;
  int          step, polls, answered, zero_target;
  int          idle_cnt = 0, wait_cnt = 0, wait_target = 0;
  bit          pend_rv = 0;
  int          rv_wait;
  bit          prev_pending = 0;
  logic [3:0]  prev_addr, prev_wstrb;
  logic [31:0] prev_wdata;

  task automatic checkOutput(input string tag, input logic [63:0] observed, input logic [63:0] expected);
    checks++;
    if (observed !== expected) begin
      errors++;
      $display("[TB] FAIL %s observed=%0h expected=%0h", tag, observed, expected);
    end
  endtask

  // Expected CSR write {addr, data} for write number s of descriptor d
  function automatic logic [35:0] exp_write(input desc_t d, input int s);
    logic [3:0]  a;
    logic [31:0] v;
    if (s == 0) begin
      a = 4'(INTERFACE_NUM); v = {28'b0, d.ifn};
    end else if (s == 1) begin
      a = 4'(DIRECTION); v = {31'b0, d.dir};
    end else if ((s == 2) == d.dir) begin
      a = 4'(TRANSFER_SIZE); v = d.size;
    end else begin
      a = 4'(BASE_ADDR); v = d.addr;
    end
    return {a, v};
  endfunction

  function automatic desc_t rand_desc(input bit allow_zero);
    desc_t d;
    d.addr = $urandom;
    d.size = (allow_zero && $urandom_range(0, 4) == 0) ? 32'd0 : 32'($urandom_range(1, 5000));
    d.dir  = 1'($urandom_range(0, 1));
    d.ifn  = 4'($urandom_range(0, 15));
    return d;
  endfunction

  function automatic int next_wait();
    return (wait_fixed >= 0) ? wait_fixed : int'($urandom_range(0, 2));
  endfunction

  task automatic answerPoll();
    iob_rvalid = 1'b1;
    iob_rdata  = (answered == zero_target) ? 32'd1 : 32'd0;
    answered++;
  endtask

  task automatic acceptReq();
    logic [35:0] e;
    int d;
    if (iob_wstrb != 4'h0) begin
      if (!active) begin
        checkOutput("write_has_desc", model_q.size() != 0, 1);
        if (model_q.size() != 0) begin
          cur = model_q[0];
          active = 1; step = 0; polls = 0; answered = 0;
          zero_target = (zero_fixed >= 0) ? zero_fixed : int'($urandom_range(0, 3));
          checkOutput("traffic_size_nonzero", cur.size != 0, 1);
        end
      end
      if (active) begin
        checkOutput("write_in_range", step < 4, 1);
        if (step < 4) begin
          e = exp_write(cur, step);
          checkOutput("wr_addr", iob_addr, e[35:32]);
          checkOutput("wr_data", iob_wdata, e[31:0]);
          checkOutput("wr_strb", iob_wstrb, 4'hF);
          if (step > 0) checkOutput("wr_gap", idle_cnt <= 1, 1);
          step++;
        end
      end
    end else begin
      checkOutput("poll_after_writes", active && step == 4, 1);
      checkOutput("poll_addr", iob_addr, cur.dir ? 4'(READY_W) : 4'(READY_R));
      if (polls == 0) checkOutput("settle_gap", idle_cnt, SETTLE);
      polls++;
      d = rv_hold ? 1000 : ((rv_fixed >= 0) ? rv_fixed : int'($urandom_range(0, 2)));
      if (d == 0) answerPoll();
      else begin
        pend_rv = 1;
        rv_wait = d - 1;
      end
    end
  endtask

  task automatic retireCheck();
    desc_t d;
    checkOutput("done_has_desc", model_q.size() != 0, 1);
    if (model_q.size() != 0) begin
      d = model_q.pop_front();
      if (active) begin
        checkOutput("done_order", d.addr, cur.addr);
        checkOutput("done_steps", step, 4);
        checkOutput("done_polls", answered, zero_target + 1);
      end else begin
        checkOutput("done_zero_size", d.size, 0);
      end
      checkOutput("done_cnt", done_cnt, done_model[15:0]);
      done_model++;
    end
    active = 0;
  endtask

  // CSR slave and traffic monitor, all decisions taken on the falling edge
  initial begin
    iob_ready = 1'b0; iob_rvalid = 1'b0; iob_rdata = '0;
    forever begin
      @(negedge clk);
      if (!arst_n) begin
        model_q.delete();
        done_model = 0; active = 0; pend_rv = 0; prev_pending = 0;
        wait_cnt = 0; idle_cnt = 0;
        iob_ready = 1'b0; iob_rvalid = 1'b0; iob_rdata = '0;
      end else begin
        if (done) retireCheck();
        if (prev_pending) begin
          checkOutput("hold_valid", iob_valid, 1);
          checkOutput("hold_addr", iob_addr, prev_addr);
          checkOutput("hold_wdata", iob_wdata, prev_wdata);
          checkOutput("hold_wstrb", iob_wstrb, prev_wstrb);
        end
        iob_rvalid = 1'b0;
        iob_rdata  = '0;
        if (pend_rv) begin
          if (rv_wait == 0) begin
            pend_rv = 0;
            answerPoll();
          end else rv_wait--;
        end
        iob_ready = 1'b0;
        if (iob_valid) begin
          if (wait_cnt >= wait_target) begin
            iob_ready = 1'b1;
            wait_cnt = 0;
            wait_target = next_wait();
            acceptReq();
            idle_cnt = 0;
          end else wait_cnt++;
        end else idle_cnt++;
        prev_pending = iob_valid && !iob_ready;
        prev_addr = iob_addr; prev_wdata = iob_wdata; prev_wstrb = iob_wstrb;
      end
    end
  end

  task automatic applyStimulus(input desc_t d);
    int n = 0;
    @(negedge clk);
    desc_valid = 1'b1;
    desc_addr = d.addr; desc_size = d.size; desc_dir = d.dir; desc_if = d.ifn;
    while (!desc_ready && n < 2000) begin
      @(negedge clk);
      n++;
    end
    checkOutput("push_accepted", n < 2000, 1);
    if (desc_ready) model_q.push_back(d);
    @(negedge clk);
    desc_valid = 1'b0;
  endtask

  task automatic waitIdle(input int budget);
    int n = 0;
    while ((busy || model_q.size() != 0 || active) && n < budget) begin
      @(negedge clk);
      n++;
    end
    checkOutput("idle_timeout", n < budget, 1);
  endtask

  task automatic waitActive();
    int n = 0;
    while (!active && n < 500) begin
      @(negedge clk);
      n++;
    end
    checkOutput("became_active", active, 1);
  endtask

  task automatic checkResetOutputs(input string tag);
    checkOutput({tag, "_desc_ready"}, desc_ready, 1);
    checkOutput({tag, "_busy"}, busy, 0);
    checkOutput({tag, "_done"}, done, 0);
    checkOutput({tag, "_done_cnt"}, done_cnt, 0);
    checkOutput({tag, "_level"}, level, 0);
    checkOutput({tag, "_iob_valid"}, iob_valid, 0);
    checkOutput({tag, "_iob_addr"}, iob_addr, 0);
    checkOutput({tag, "_iob_wdata"}, iob_wdata, 0);
    checkOutput({tag, "_iob_wstrb"}, iob_wstrb, 0);
  endtask

  initial begin
    #1000000;
    $display("[TB] FAIL watchdog expired observed=running expected=finished");
    $fatal(1, "[TB] watchdog");
  end

  initial begin
    int n;
    arst_n = 1'b0; cke = 1'b1; desc_valid = 1'b0; flush = 1'b0;
    desc_addr = '0; desc_size = '0; desc_dir = 1'b0; desc_if = '0;
    #12;
    checkResetOutputs("reset");
    @(negedge clk);
    #1 arst_n = 1'b1;

    // memory to stream, immediate acks, two not-ready polls
    zero_fixed = 2; wait_fixed = 0; rv_fixed = 0;
    applyStimulus('{addr: 32'h100, size: 32'd8, dir: 1'b0, ifn: 4'd1});
    waitIdle(500);
    checkOutput("t1_done_cnt", done_cnt, 1);

    // stream to memory: size before base, READY_W polled
    zero_fixed = 1;
    applyStimulus('{addr: 32'h2000, size: 32'd16, dir: 1'b1, ifn: 4'd3});
    waitIdle(500);
    checkOutput("t2_done_cnt", done_cnt, 2);

    // every request stalled for five cycles
    wait_fixed = 5; wait_target = 5; rv_fixed = 1; zero_fixed = -1;
    applyStimulus(rand_desc(0));
    applyStimulus(rand_desc(0));
    waitIdle(2000);
    checkOutput("t3_done_cnt", done_cnt, 4);

    // zero-size descriptor between two real ones
    wait_fixed = -1; rv_fixed = -1;
    applyStimulus('{addr: 32'h300, size: 32'd20, dir: 1'b0, ifn: 4'd2});
    applyStimulus('{addr: 32'h400, size: 32'd0, dir: 1'b1, ifn: 4'd5});
    applyStimulus('{addr: 32'h500, size: 32'd7, dir: 1'b1, ifn: 4'd6});
    waitIdle(2000);
    checkOutput("t4_done_cnt", done_cnt, 7);

    // fill the FIFO behind an active descriptor
    wait_fixed = 5; wait_target = 5; zero_fixed = 3;
    applyStimulus(rand_desc(0));
    waitActive();
    for (int i = 0; i < 8; i++) applyStimulus(rand_desc(1));
    checkOutput("full_level", level, 8);
    checkOutput("full_ready", desc_ready, 0);
    wait_fixed = -1; zero_fixed = -1;
    waitIdle(5000);
    checkOutput("t5_done_cnt", done_cnt, 16);

    // flush with four queued and one active; same-cycle push is dropped
    wait_fixed = 5; wait_target = 5; zero_fixed = 2;
    applyStimulus(rand_desc(0));
    waitActive();
    for (int i = 0; i < 4; i++) applyStimulus(rand_desc(0));
    checkOutput("pre_flush_level", level, 4);
    flush = 1'b1;
    desc_valid = 1'b1; desc_addr = 32'hDEAD; desc_size = 32'd9;
    @(negedge clk);
    flush = 1'b0; desc_valid = 1'b0;
    while (model_q.size() > 1) void'(model_q.pop_back());
    checkOutput("flush_level", level, 0);
    wait_fixed = -1; zero_fixed = -1;
    waitIdle(2000);
    checkOutput("t6_done_cnt", done_cnt, 17);

    // clock enable low blocks pushes
    @(negedge clk);
    cke = 1'b0; desc_valid = 1'b1; desc_size = 32'd3;
    repeat (2) @(negedge clk);
    checkOutput("cke_level", level, 0);
    checkOutput("cke_busy", busy, 0);
    desc_valid = 1'b0; cke = 1'b1;

    // random traffic
    for (int i = 0; i < 30; i++) begin
      applyStimulus(rand_desc(1));
      repeat ($urandom_range(0, 20)) @(negedge clk);
    end
    waitIdle(20000);
    checkOutput("t8_done_cnt", done_cnt, 16'(47));

    // reset while waiting for poll data
    rv_hold = 1;
    applyStimulus(rand_desc(0));
    n = 0;
    while (!pend_rv && n < 1000) begin
      @(negedge clk);
      n++;
    end
    checkOutput("reached_poll_wait", pend_rv, 1);
    @(posedge clk);
    #2 arst_n = 1'b0;
    #1 checkResetOutputs("midreset");
    repeat (2) @(negedge clk);
    rv_hold = 0;
    #1 arst_n = 1'b1;
    zero_fixed = 1;
    applyStimulus('{addr: 32'h600, size: 32'd4, dir: 1'b0, ifn: 4'd9});
    waitIdle(1000);
    checkOutput("t9_done_cnt", done_cnt, 1);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/iob_dma_sched.md
Name: iob_dma_sched

Overview:
- Descriptor-driven sequencer that sits in front of the iob_dma CSR port (iob native master) and runs queued transfers back to back.
- Software or an upstream block pushes descriptors (base address, size, direction, stream interface) into an internal FIFO.
- Per descriptor, the block programs the DMA CSRs in the required order, waits for start to settle, then polls READY_R/READY_W until done, and moves to the next.

Parameters:
- ADDR_W, 32, DMA base/AXI address width carried in descriptors
- SIZE_W, 32, transfer size width (words)
- IF_W, 4, interface-select width
- CSR_ADDR_W, 4, iob address width of the DMA CSR bank
- DEPTH_LOG2, 3, descriptor FIFO depth = 2**DEPTH_LOG2
- SETTLE_CYC, 4, idle cycles between the start write and the first poll (≥3, covers the DMA's 2-flop write-pulse path)

Ports:
- clk_i  in  1  clock
- arst_n_i  in  1  asynchronous active-low reset
- cke_i  in  1  clock enable; all state holds when low
- desc_valid_i  in  1  descriptor push valid
- desc_ready_o  out  1  FIFO not full
- desc_addr_i  in  ADDR_W  base address
- desc_size_i  in  SIZE_W  transfer size in words
- desc_dir_i  in  1  1 = AXIS→memory (write), 0 = memory→AXIS (read)
- desc_if_i  in  IF_W  AXIS interface number
- flush_i  in  1  discard all queued (not active) descriptors
- busy_o  out  1  FSM not IDLE or FIFO non-empty
- done_o  out  1  one-cycle pulse per retired descriptor
- done_cnt_o  out  16  retired-descriptor counter, wraps
- level_o  out  DEPTH_LOG2+1  FIFO occupancy
- iob_valid_o  out  1  CSR request
- iob_addr_o  out  CSR_ADDR_W  CSR address
- iob_wdata_o  out  32  write data
- iob_wstrb_o  out  4  4'hF write, 4'h0 read
- iob_ready_i  in  1  request accepted
- iob_rvalid_i  in  1  read data valid
- iob_rdata_i  in  32  read data

Behaviour:
- Reset values: all outputs 0 except desc_ready_o = 1. FIFO is empty and FSM is in IDLE.
- FIFO:
  - Push when desc_valid_i & desc_ready_o.
  - Pop only in IDLE when non-empty.
  - Push and pop in the same cycle are both honoured and level_o is unchanged.
  - Pointers wrap modulo 2**DEPTH_LOG2.
  - level_o is registered.
- flush_i: empties the FIFO in the next cycle. Has no effect on the active descriptor; that descriptor completes and retires normally. A push in the same cycle as flush_i is dropped.
- FSM states: IDLE → LOAD → WR_IF → WR_DIR → WR_A → WR_B → SETTLE → POLL_REQ → POLL_WAIT → RETIRE → IDLE.
  - LOAD: latches the popped descriptor. A size-0 descriptor goes directly to RETIRE with no CSR traffic.
  - WR_* states: hold iob_valid_o=1 with stable addr/wdata/wstrb until iob_ready_i; advance in the cycle after acceptance.
  - The bus is never idle between accepted writes for more than 1 cycle.
  - WR_IF writes INTERFACE_NUM = desc_if; WR_DIR writes DIRECTION = desc_dir.
  - Write order for dir=1: WR_A = TRANSFER_SIZE (clears the stream counter), then WR_B = BASE_ADDR (starts the transfer).
  - Write order for dir=0: WR_A = BASE_ADDR, then WR_B = TRANSFER_SIZE (starts the transfer).
  - Written data is zero-extended to 32 bits.
  - SETTLE: counts SETTLE_CYC cycles with iob_valid_o=0.
  - POLL_REQ: read request (wstrb 0) to READY_W if dir=1, else READY_R; hold until iob_ready_i.
  - POLL_WAIT: waits for iob_rvalid_i. rdata[0]=1 → RETIRE; else → POLL_REQ. rvalid in the same cycle as ready is accepted.
  - RETIRE: done_o=1 for one cycle and done_cnt_o++ (16-bit wrap), then → IDLE.
- A new descriptor starts at the earliest 2 cycles after RETIRE.
- Reset mid-operation: everything returns immediately to reset values. The DMA itself is not cancelled; software re-arms it.
- busy_o is combinational from state and level.

Decomposition:
- Shared header iob_dma_sched_defs.vh holds:
  - CSR address localparams: INTERFACE_NUM, DIRECTION, BASE_ADDR, TRANSFER_SIZE, READY_R, READY_W, matching iob_dma_swreg_def.
  - State encodings.
  - Descriptor packed width, ADDR_W+SIZE_W+1+IF_W.
- One sub-module, iob_dma_sched_fifo: a synchronous register FIFO carrying packed descriptors, with level and flush.

Test Plan:
- Push one descriptor {addr=0x100, size=8, dir=0, if=1}; slave acks immediately, READY_R reads 0 twice then 1 → writes IF=1, DIR=0, BASE_ADDR=0x100, then TRANSFER_SIZE=8, 4 idle cycles, 3 polls, one done_o, done_cnt_o=1.
- Descriptor dir=1, size=16 → TRANSFER_SIZE write precedes BASE_ADDR; polls target READY_W.
- Slave holds iob_ready_i low for 5 cycles on every request → addr/wdata/wstrb stable throughout; sequence unchanged.
- Push 8 descriptors while the first is active → desc_ready_o=0 after the 8th queued entry (level_o=8); all 9 retire in push order; done_cnt_o=9.
- Size-0 descriptor between two normal ones → zero CSR accesses for it; done_o pulses 3 times total.
- flush_i with 4 queued and one active → level_o=0 next cycle; active descriptor completes; done_cnt_o increments by 1 only.
- arst_n_i low during POLL_WAIT → all outputs at reset values; FIFO empty; next descriptor runs from WR_IF.
